// File: rtl/io_port_bank_pkg.sv
// Shared constants for the io_port_bank register window.
package io_port_bank_pkg;

    localparam int WINDOW_SIZE = 16;

    localparam logic [3:0] OFS_OUT    = 4'h0;
    localparam logic [3:0] OFS_IN     = 4'h4;
    localparam logic [3:0] OFS_PEND   = 4'h8;
    localparam logic [3:0] OFS_MASK   = 4'h9;
    localparam logic [3:0] OFS_NMISEL = 4'hA;
    localparam logic [3:0] OFS_STATUS = 4'hB;
    localparam logic [3:0] OFS_SWSET  = 4'hC;

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse taken from the synchronised value.
module io_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    // Metastability chain plus one bit of history for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped output/input ports and edge-triggered interrupt controller for the cpu6502 bus.
module io_port_bank #(
    parameter int                  ADDR_W    = 16,
    parameter int                  DATA_W    = 8,
    parameter int                  NUM_PORTS = 4,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = 16'hbff0,
    parameter logic [DATA_W-1:0]   OUT_RESET = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          write,
    input  logic                          ready,
    output logic [DATA_W-1:0]             data_o,
    output logic                          cs,
    output logic [NUM_PORTS*DATA_W-1:0]   port_out,
    input  logic [NUM_PORTS*DATA_W-1:0]   port_in,
    input  logic [DATA_W-1:0]             irq_src,
    output logic                          irq,
    output logic                          nmi
);

    import io_port_bank_pkg::*;

    localparam int OFS_W = $clog2(WINDOW_SIZE);

    logic [OFS_W-1:0]              off;
    logic                          we;
    logic [DATA_W-1:0]             out_q [NUM_PORTS];
    logic [DATA_W-1:0]             pend_q, mask_q, nmisel_q;
    logic [DATA_W-1:0]             pend_d, mask_d, nmisel_d;
    logic                          irq_q, nmi_q;
    logic [NUM_PORTS*DATA_W-1:0]   in_sync;
    logic [NUM_PORTS*DATA_W-1:0]   in_rise_unused;
    logic [DATA_W-1:0]             src_sync_unused;
    logic [DATA_W-1:0]             src_rise;

    assign off = address[OFS_W-1:0];
    assign cs  = (address[ADDR_W-1:OFS_W] == BASE_ADDR[ADDR_W-1:OFS_W]);
    assign we  = cs & write & ready;

    io_sync_edge #(.W(DATA_W)) u_src_sync (
        .clk  (clk),
        .reset(reset),
        .d    (irq_src),
        .q    (src_sync_unused),
        .rise (src_rise)
    );

    io_sync_edge #(.W(NUM_PORTS*DATA_W)) u_in_sync (
        .clk  (clk),
        .reset(reset),
        .d    (port_in),
        .q    (in_sync),
        .rise (in_rise_unused)
    );

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [OFS_W-1:0] PORT_OFS = OFS_OUT + OFS_W'(p);

        // Output port register, written through its own offset.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                out_q[p] <= OUT_RESET;
            end else if (we && off == PORT_OFS) begin
                out_q[p] <= data_i;
            end
        end

        assign port_out[p*DATA_W +: DATA_W] = out_q[p];
    end

    // Next-state of the interrupt registers; a hardware edge is ORed last so it beats W1C.
    always_comb begin
        pend_d   = pend_q;
        mask_d   = mask_q;
        nmisel_d = nmisel_q;
        if (we) begin
            case (off)
                OFS_PEND:   pend_d   = pend_q & ~data_i;
                OFS_MASK:   mask_d   = data_i;
                OFS_NMISEL: nmisel_d = data_i;
                OFS_SWSET:  pend_d   = pend_q | data_i;
                default:    ;
            endcase
        end
        pend_d = pend_d | src_rise;
    end

    // Interrupt state; irq/nmi are registered from next-state so they track writes in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q   <= '0;
            mask_q   <= '0;
            nmisel_q <= '0;
            irq_q    <= 1'b0;
            nmi_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            nmisel_q <= nmisel_d;
            irq_q    <= |(pend_d & mask_d & ~nmisel_d);
            nmi_q    <= |(pend_d & mask_d & nmisel_d);
        end
    end

    assign irq = irq_q;
    assign nmi = nmi_q;

    // Side-effect-free read mux; unimplemented ports and reserved offsets read zero.
    always_comb begin
        data_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (off == OFS_OUT + OFS_W'(p)) data_o = out_q[p];
            if (off == OFS_IN + OFS_W'(p))  data_o = in_sync[p*DATA_W +: DATA_W];
        end
        case (off)
            OFS_PEND:   data_o = pend_q;
            OFS_MASK:   data_o = mask_q;
            OFS_NMISEL: data_o = nmisel_q;
            OFS_STATUS: data_o = {{(DATA_W-2){1'b0}}, nmi_q, irq_q};
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: behavioural model plus directed literal checks.
module tb_io_port_bank;

    localparam int          ADDR_W = 16;
    localparam int          DATA_W = 8;
    localparam int          NP     = 4;
    localparam logic [15:0] BASE   = 16'hbff0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = BASE;
    logic [7:0]  data_i = 8'h00;
    logic        write = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  data_o;
    logic        cs;
    logic [31:0] port_out;
    logic [31:0] port_in = 32'h0;
    logic [7:0]  irq_src = 8'h00;
    logic        irq;
    logic        nmi;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    io_port_bank #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_PORTS(NP),
        .BASE_ADDR(BASE), .OUT_RESET(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .data_i(data_i),
        .write(write), .ready(ready), .data_o(data_o), .cs(cs),
        .port_out(port_out), .port_in(port_in), .irq_src(irq_src),
        .irq(irq), .nmi(nmi)
    );

    always #5 clk = ~clk;

    // Behavioural model: register contents plus sample histories of the async inputs.
    logic [7:0]  m_out [4];
    logic [7:0]  m_pend, m_mask, m_nsel;
    logic        m_irq, m_nmi;
    logic [31:0] in_h [2];
    logic [7:0]  src_h [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
        m_pend = 0; m_mask = 0; m_nsel = 0; m_irq = 0; m_nmi = 0;
        in_h[0] = 0; in_h[1] = 0;
        src_h[0] = 0; src_h[1] = 0; src_h[2] = 0;
    endtask

    task automatic model_step();
        logic [7:0] rise;
        logic       wr_en;
        logic [3:0] o;
        // an edge on the source seen two and three samples back is the one the bank acts on now
        rise  = src_h[1] & ~src_h[2];
        wr_en = (address[15:4] == BASE[15:4]) && write && ready;
        o     = address[3:0];
        if (wr_en) begin
            if (int'(o) < NP) m_out[o[1:0]] = data_i;
            if (o == 4'h8) m_pend = m_pend & ~data_i;
            if (o == 4'h9) m_mask = data_i;
            if (o == 4'hA) m_nsel = data_i;
            if (o == 4'hC) m_pend = m_pend | data_i;
        end
        m_pend = m_pend | rise;
        src_h[2] = src_h[1]; src_h[1] = src_h[0]; src_h[0] = irq_src;
        in_h[1] = in_h[0]; in_h[0] = port_in;
        m_irq = |(m_pend & m_mask & ~m_nsel);
        m_nmi = |(m_pend & m_mask & m_nsel);
    endtask

    function automatic logic [7:0] exp_rd(input logic [3:0] o);
        if (int'(o) < NP) return m_out[o[1:0]];
        if (o >= 4'h4 && o <= 4'h7) return in_h[1][(int'(o) - 4)*8 +: 8];
        case (o)
            4'h8:    return m_pend;
            4'h9:    return m_mask;
            4'hA:    return m_nsel;
            4'hB:    return {6'b0, m_nmi, m_irq};
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else        model_step();
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                chk("cs", cs, address[15:4] == BASE[15:4]);
                if (cs) chk("data_o", data_o, exp_rd(address[3:0]));
                chk("irq", irq, m_irq);
                chk("nmi", nmi, m_nmi);
                chk("port_out", port_out, {m_out[3], m_out[2], m_out[1], m_out[0]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic r);
        address = a; data_i = d; write = 1'b1; ready = r;
        cyc();
        write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        address = a;
        #1;
        chk(name, data_o, exp);
    endtask

    initial begin
        repeat (3) cyc();
        reset = 1'b1;
        run_cmp = 1'b1;

        chk("rst_irq", irq, 1'b0);
        chk("rst_nmi", nmi, 1'b0);
        chk("rst_port_out", port_out, 32'h0);
        for (int o = 0; o <= 12; o++) rd_chk("rst_read", BASE + 16'(o), 8'h00);
        address = 16'hbff0; #1; chk("cs_in", cs, 1'b1);
        address = 16'hbfef; #1; chk("cs_out", cs, 1'b0);
        cyc();

        wr(16'hbff2, 8'hA5, 1'b1);
        chk("out2_write", port_out[23:16], 8'hA5);
        wr(16'hbff2, 8'h5A, 1'b0);
        chk("out2_stall", port_out[23:16], 8'hA5);

        wr(16'hbff9, 8'h01, 1'b1);
        irq_src = 8'h01;
        cyc(); chk("irq_edge1", irq, 1'b0);
        cyc(); chk("irq_edge2", irq, 1'b0);
        cyc(); chk("irq_edge3", irq, 1'b1);
        rd_chk("pend_set", 16'hbff8, 8'h01);
        irq_src = 8'h00;
        wr(16'hbff8, 8'h01, 1'b1);
        chk("irq_w1c", irq, 1'b0);

        wr(16'hbffa, 8'h02, 1'b1);
        wr(16'hbff9, 8'h03, 1'b1);
        wr(16'hbffc, 8'h02, 1'b1);
        chk("nmi_swset", nmi, 1'b1);
        chk("irq_not_nmi", irq, 1'b0);
        rd_chk("status", 16'hbffb, 8'h02);
        wr(16'hbff8, 8'h02, 1'b1);
        chk("nmi_clear", nmi, 1'b0);

        wr(16'hbffc, 8'h01, 1'b1);
        chk("irq_sw", irq, 1'b1);
        irq_src = 8'h01;
        cyc();
        cyc();
        address = 16'hbff8; data_i = 8'h01; write = 1'b1; ready = 1'b1;
        cyc();
        write = 1'b0;
        chk("conflict_irq", irq, 1'b1);
        rd_chk("conflict_pend", 16'hbff8, 8'h01);
        irq_src = 8'h00;
        wr(16'hbff8, 8'h01, 1'b1);
        chk("conflict_clear", irq, 1'b0);

        port_in = 32'h0000_3C00;
        address = 16'hbff5;
        cyc(); chk("in_edge1", data_o, 8'h00);
        cyc(); chk("in_edge2", data_o, 8'h3C);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) != 0) address = BASE | 16'($urandom_range(0, 15));
            else                           address = 16'($urandom);
            data_i  = 8'($urandom);
            write   = ($urandom_range(0, 2) != 0);
            ready   = ($urandom_range(0, 3) != 0);
            irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 7) == 0) port_in = $urandom;
            cyc();
        end
        write = 1'b0;
        irq_src = 8'h00;
        cyc();

        address = 16'hbff0; data_i = 8'h77; write = 1'b1; ready = 1'b1;
        cyc();
        chk("pre_reset_out0", port_out[7:0], 8'h77);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out", port_out, 32'h0);
        chk("async_rst_irq", irq, 1'b0);
        chk("async_rst_nmi", nmi, 1'b0);
        rd_chk("async_rst_mask", 16'hbff9, 8'h00);
        write = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Memory-mapped I/O port and interrupt block for the cpu6502 bus, replacing the single hard-decoded output byte whose bits drove `irq`/`nmi` directly. It decodes a 16-byte window at a parametrised base address and provides `NUM_PORTS` output and input registers. It also contains an edge-triggered interrupt controller with pending, mask and NMI-routing registers that drives the CPU's `irq` and `nmi` inputs. It sits between the cpu6502 core and external logic, alongside the memory on the same address/data bus.

## Interface
- `ADDR_W`, 16: CPU address width.
- `DATA_W`, 8: register and bus data width.
- `NUM_PORTS`, 4: number of output/input ports; legal range 1..4.
- `BASE_ADDR`, 16'hbff0: window base; low 4 bits must be 0.
- `OUT_RESET`, 0: reset value of every output port register.

- `clk` in 1: CPU clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `address` in ADDR_W: CPU address.
- `data_i` in DATA_W: CPU write data (cpu6502 `data_o`).
- `write` in 1: CPU write strobe.
- `ready` in 1: CPU ready; writes commit only when high.
- `data_o` out DATA_W: read data to the CPU data mux.
- `cs` out 1: address falls inside the window; the bus mux selects `data_o` and suppresses the memory write.
- `port_out` out NUM_PORTS*DATA_W: output registers; port p occupies bits [p*DATA_W +: DATA_W].
- `port_in` in NUM_PORTS*DATA_W: asynchronous external inputs.
- `irq_src` in DATA_W: asynchronous interrupt sources, rising-edge sensitive.
- `irq` out 1: active-high maskable interrupt to cpu6502.
- `nmi` out 1: active-high NMI request to cpu6502.

## Operation
- `cs` = (`address[ADDR_W-1:4]` == `BASE_ADDR[ADDR_W-1:4]`). It is combinational.
- Register map, by offset in `address[3:0]`:
  - 0x0–0x3 OUT[p]: read/write.
  - 0x4–0x7 IN[p]: read-only, synchronised `port_in`.
  - 0x8 PEND: read; write-1-to-clear.
  - 0x9 MASK: read/write.
  - 0xA NMISEL: read/write.
  - 0xB STATUS: read-only; {0…, nmi, irq}.
  - 0xC SWSET: write-1-to-set PEND; reads as 0.
  - 0xD–0xF: reserved; reads 0, writes ignored.
- Offsets for p ≥ `NUM_PORTS` behave as reserved.
- A write commits on a `clk` rising edge when `cs & write & ready`.
- Reads are combinational from the current register state and have no side effects.
- `port_in` and `irq_src` each pass through a 2-flop synchroniser.
- A rising edge on synchronised `irq_src[i]` (previous 0, current 1) sets PEND[i].
- `irq` = |(PEND & MASK & ~NMISEL).
- `nmi` = |(PEND & MASK & NMISEL).
- Both outputs are registered from the next-state values, so they are glitch-free.
- `nmi` is held until software clears PEND. The CPU's edge detect sees one edge per assertion.
- Same-cycle conflicts:
  - Hardware edge set and PEND W1C on the same bit: the set wins, and the bit stays 1.
  - SWSET and hardware edge: the result is the OR of both.
  - MASK written in the same cycle PEND sets: the new MASK is used for the registered `irq`/`nmi`.

## Timing
- Reset values:
  - OUT[p] = `OUT_RESET`.
  - MASK, NMISEL, PEND, synchronisers and edge history = 0.
  - `irq` = `nmi` = 0.
- `cs` and `data_o` are combinational; there are no outputs during reset except the reset values.
- Register write to visible `port_out`: 1 edge.
- A write to MASK/NMISEL/PEND/SWSET affects `irq`/`nmi` after the same edge, i.e. 1 cycle.
- `irq_src` rise to `irq`/`nmi` high: 3 edges: 2 synchroniser edges, then the PEND set with registered `irq` on the same edge.
- `port_in` change to IN readback: 2 edges.
- `ready` low stalls the write; the register holds its value.
- Asserting `reset` mid-operation returns all state to reset values immediately, independent of `clk`.

## Structure
- Package `io_port_bank_pkg` holds:
  - offset constants: OFS_OUT, OFS_IN, OFS_PEND, OFS_MASK, OFS_NMISEL, OFS_STATUS, OFS_SWSET;
  - the window size constant, 16.
- Sub-module `io_sync_edge #(W)`: 2-flop synchroniser plus a rising-edge pulse output. It is instantiated once for `irq_src` (W=DATA_W) and once for `port_in` (edge output unused).

## Test plan
- Reset then read 0xbff0–0xbffc → OUT = `OUT_RESET`, PEND = MASK = NMISEL = 0, `irq` = `nmi` = 0, `cs` = 1. Address 0xbfef → `cs` = 0.
- Write 0xA5 to 0xbff2 with `ready` = 1 → `port_out[23:16]` = 0xA5 one edge later. Repeat with `ready` = 0 → value unchanged.
- MASK = 0x01, pulse `irq_src[0]` → `irq` = 1 three edges after the rise, PEND = 0x01. Write 0x01 to 0xbff8 → `irq` = 0 next edge.
- NMISEL = 0x02, MASK = 0x02, write 0x02 to SWSET → `nmi` = 1 and `irq` = 0 next edge, STATUS = 0x02.
- On the same edge, write W1C 0x01 and deliver a hardware edge on source 0 → PEND[0] stays 1 and `irq` stays 1.
- Set `port_in` port 1 to 0x3C → read 0xbff5 = 0x3C from the 2nd edge onward. Assert `reset` mid-write → all registers return to reset values asynchronously.
